// File: rtl/serial_subn.sv
// +----------------------------------------------------------------------------+
// | serial_subn                                                                |
// | Bit-serial N-bit subtractor, LSB first, valid/ready on both sides.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module serial_subn #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] d,
  output logic         bout
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_busy = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  localparam logic [CW-1:0] c_last = CW'(N - 1);

  logic [1:0]    r_state;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [N-1:0]  r_sh;
  logic [N-1:0]  r_d;
  logic          r_br;
  logic          r_bout;
  logic [CW-1:0] r_cnt;

  logic          w_x;
  logic          w_y;
  logic          w_diff;
  logic          w_bnext;
  logic [N-1:0]  w_sh_next;

  // Single full-subtractor cell working on the operand LSBs.
  assign w_x       = r_a[0];
  assign w_y       = r_b[0];
  assign w_diff    = w_x ^ w_y ^ r_br;
  assign w_bnext   = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
  assign w_sh_next = {w_diff, r_sh[N-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
      r_a     <= '0;
      r_b     <= '0;
      r_sh    <= '0;
      r_d     <= '0;
      r_br    <= 1'b0;
      r_bout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_br    <= bin;
            r_cnt   <= '0;
            r_sh    <= '0;
            r_state <= c_busy;
          end
        end
        c_busy: begin
          r_sh  <= w_sh_next;
          r_a   <= {1'b0, r_a[N-1:1]};
          r_b   <= {1'b0, r_b[N-1:1]};
          r_br  <= w_bnext;
          r_cnt <= r_cnt + CW'(1);
          // Visible result only changes when a full word has been produced.
          if (r_cnt == c_last) begin
            r_d     <= w_sh_next;
            r_bout  <= w_bnext;
            r_state <= c_done;
          end
        end
        c_done: begin
          if (out_ready) begin
            r_state <= c_idle;
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  assign in_ready  = (r_state == c_idle);
  assign out_valid = (r_state == c_done);
  assign d         = r_d;
  assign bout      = r_bout;

endmodule

`default_nettype wire

// File: tb/tb_serial_subn.sv
// +----------------------------------------------------------------------------+
// | tb_serial_subn                                                             |
// | Directed and randomized checks of serial_subn at N=8, N=2 and N=16.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_serial_subn;

  logic        clk;
  logic        rst_n;
  logic [2:0]  iv;
  logic [2:0]  ordy;
  logic [2:0]  tbin;
  logic [15:0] ta  [3];
  logic [15:0] tbv [3];
  wire  [2:0]  ir;
  wire  [2:0]  ov;
  wire  [2:0]  bo;
  wire  [7:0]  d8;
  wire  [1:0]  d2;
  wire  [15:0] d16;

  int n_checks;
  int n_errors;

  serial_subn #(.N(8)) u_n8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(ta[0][7:0]), .b(tbv[0][7:0]), .bin(tbin[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .d(d8), .bout(bo[0])
  );

  serial_subn #(.N(2)) u_n2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(ta[1][1:0]), .b(tbv[1][1:0]), .bin(tbin[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .d(d2), .bout(bo[1])
  );

  serial_subn #(.N(16)) u_n16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(ta[2]), .b(tbv[2]), .bin(tbin[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .d(d16), .bout(bo[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL timeout no summary reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int width_of(input int idx);
    return (idx == 0) ? 8 : (idx == 1) ? 2 : 16;
  endfunction

  function automatic logic [15:0] dout(input int idx);
    case (idx)
      0:       return {8'h00, d8};
      1:       return {14'h0, d2};
      default: return d16;
    endcase
  endfunction

  // One full transaction: present, await result, hold for 'stall' cycles, release.
  task automatic xact(input int idx, input logic [15:0] av, input logic [15:0] bv,
                      input logic bi, input logic [15:0] ed, input logic eb,
                      input int stall, input bit jitter);
    int cyc;
    @(negedge clk);
    ta[idx] = av; tbv[idx] = bv; tbin[idx] = bi;
    iv[idx] = 1'b1; ordy[idx] = (stall == 0);
    check("accept_ready", ir[idx], 1'b1);
    @(negedge clk);
    iv[idx] = 1'b0;
    cyc = 0;
    while (!ov[idx] && cyc < 40) begin
      check("busy_no_ready", ir[idx], 1'b0);
      @(negedge clk);
      cyc++;
      if (jitter) begin
        ta[idx] = 16'($urandom); tbv[idx] = 16'($urandom); tbin[idx] = 1'($urandom);
      end
    end
    check("latency", cyc, width_of(idx));
    check("d", dout(idx), ed);
    check("bout", bo[idx], eb);
    check("done_no_ready", ir[idx], 1'b0);
    repeat (stall) begin
      @(negedge clk);
      check("stall_valid", ov[idx], 1'b1);
      check("stall_d", dout(idx), ed);
      check("stall_bout", bo[idx], eb);
    end
    ordy[idx] = 1'b1;
    @(negedge clk);
    check("release_valid", ov[idx], 1'b0);
    check("release_ready", ir[idx], 1'b1);
  endtask

  task automatic random_run(input int idx);
    logic [15:0] mask, av, bv, ed;
    logic        bi, eb;
    logic [16:0] full;
    mask = 16'((32'd1 << width_of(idx)) - 1);
    for (int k = 0; k < 200; k++) begin
      av   = 16'($urandom) & mask;
      bv   = 16'($urandom) & mask;
      bi   = 1'($urandom);
      full = {1'b0, av} - {1'b0, bv} - {16'h0, bi};
      ed   = full[15:0] & mask;
      eb   = ({1'b0, av} < ({1'b0, bv} + {16'h0, bi}));
      xact(idx, av, bv, bi, ed, eb, int'($urandom_range(0, 3)), 1'b0);
    end
  endtask

  initial begin
    int cyc;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    iv = '0; ordy = '1; tbin = '0;
    for (int i = 0; i < 3; i++) begin ta[i] = '0; tbv[i] = '0; end
    iv[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", ir[0], 1'b1);
    check("rst_valid", ov[0], 1'b0);
    check("rst_d", dout(0), 16'h0);
    check("rst_bout", bo[0], 1'b0);
    iv[0] = 1'b0;
    rst_n = 1'b1;

    xact(0, 16'h5A, 16'h3C, 1'b0, 16'h1E, 1'b0, 0, 1'b0);
    xact(0, 16'h00, 16'h01, 1'b0, 16'hFF, 1'b1, 0, 1'b0);
    xact(0, 16'h10, 16'h0F, 1'b1, 16'h00, 1'b0, 0, 1'b0);
    xact(0, 16'h00, 16'hFF, 1'b1, 16'h00, 1'b1, 0, 1'b0);

    // Backpressure with a second request waiting throughout.
    @(negedge clk);
    ta[0] = 16'h80; tbv[0] = 16'h01; tbin[0] = 1'b0; iv[0] = 1'b1; ordy[0] = 1'b0;
    @(negedge clk);
    ta[0] = 16'h44; tbv[0] = 16'h11;
    cyc = 0;
    while (!ov[0] && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("bp_latency", cyc, 8);
    for (int s = 0; s < 5; s++) begin
      if (s > 0) @(negedge clk);
      check("bp_valid", ov[0], 1'b1);
      check("bp_d", dout(0), 16'h7F);
      check("bp_bout", bo[0], 1'b0);
      check("bp_ready", ir[0], 1'b0);
    end
    ordy[0] = 1'b1;
    @(negedge clk);
    check("bp_release", ov[0], 1'b0);
    check("bp_idle", ir[0], 1'b1);
    @(negedge clk);
    iv[0] = 1'b0;
    check("bp_second_busy", ir[0], 1'b0);
    cyc = 0;
    while (!ov[0] && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("bp2_latency", cyc, 8);
    check("bp2_d", dout(0), 16'h33);
    check("bp2_bout", bo[0], 1'b0);
    @(negedge clk);

    xact(0, 16'hA5, 16'h5A, 1'b1, 16'h4A, 1'b0, 0, 1'b1);

    // Reset after bit 3 of an in-flight operation.
    @(negedge clk);
    ta[0] = 16'hFF; tbv[0] = 16'h01; tbin[0] = 1'b0; iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", ov[0], 1'b0);
    check("mid_rst_d", dout(0), 16'h0);
    check("mid_rst_bout", bo[0], 1'b0);
    check("mid_rst_ready", ir[0], 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    xact(0, 16'h03, 16'h01, 1'b0, 16'h02, 1'b0, 0, 1'b0);

    random_run(1);
    random_run(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
